// File: rtl/div_pkg.sv
// Shared constants for the iterative divider: FSM encoding, default width and
// the bit-counter sizing helper.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  // FSM encoding, kept as plain localparams so older tools can consume it.
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  // Bits needed for a counter that runs WIDTH-1 down to 0.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

  localparam int unsigned DIV_CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/div_step.sv
// One non-restoring division step: shift {A,Qw} left by one, then add or
// subtract the divisor according to the sign of A, then write the quotient bit.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [2*WIDTH:0] aq_i,   // {A (WIDTH+1 bits, signed), Qw (WIDTH bits)}
  input  logic [WIDTH-1:0] dvsr_i, // divisor magnitude
  output logic [2*WIDTH:0] aq_o
);

  logic [WIDTH:0] a_sh;
  logic [WIDTH:0] a_new;

  // Shift, add/sub, and quotient-bit insertion.
  always_comb begin
    // A's range keeps the shifted value inside WIDTH+1 signed bits, so the
    // pre-shift sign bit is also the sign of the shifted A.
    a_sh = aq_i[2*WIDTH-1:WIDTH-1];
    if (aq_i[2*WIDTH]) begin
      a_new = a_sh + {1'b0, dvsr_i};
    end else begin
      a_new = a_sh - {1'b0, dvsr_i};
    end
    aq_o = {a_new, aq_i[WIDTH-2:0], ~a_new[WIDTH]};
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative signed divider, one quotient bit per clock. Quotient feeds LO,
// remainder feeds HI. Quotient truncates toward zero; remainder follows the
// dividend's sign.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] Dvnd,
  input  logic [WIDTH-1:0] Dvsr,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_by_zero
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [2*WIDTH:0] aq_q, aq_d, aq_step;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             qsign_q, qsign_d;
  logic             rsign_q, rsign_d;
  logic             zero_q, zero_d;    // divisor was zero at accept
  logic             fixed_q, fixed_d;  // remainder correction already applied
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] dvnd_mag, dvsr_mag, r_src;
  logic [WIDTH:0]   a_fix;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .aq_i   (aq_q),
    .dvsr_i (dvsr_q),
    .aq_o   (aq_step)
  );

  // Operand magnitudes; |most-negative| is exact as an unsigned value.
  always_comb begin
    dvnd_mag = Dvnd[WIDTH-1] ? (~Dvnd + WIDTH'(1)) : Dvnd;
    dvsr_mag = Dvsr[WIDTH-1] ? (~Dvsr + WIDTH'(1)) : Dvsr;
    a_fix    = aq_q[2*WIDTH:WIDTH] + {1'b0, dvsr_q};
    // On divide-by-zero no steps ran, so Qw still holds |Dvnd|.
    r_src    = zero_q ? aq_q[WIDTH-1:0] : aq_q[2*WIDTH-1:WIDTH];
  end

  // Next-state logic for the FSM and datapath.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    aq_d    = aq_q;
    dvsr_d  = dvsr_q;
    qsign_d = qsign_q;
    rsign_d = rsign_q;
    zero_d  = zero_q;
    fixed_d = fixed_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          aq_d    = {{(WIDTH + 1){1'b0}}, dvnd_mag};
          dvsr_d  = dvsr_mag;
          qsign_d = Dvnd[WIDTH-1] ^ Dvsr[WIDTH-1];
          rsign_d = Dvnd[WIDTH-1];
          cnt_d   = CntW'(WIDTH - 1);
          if (Dvsr == '0) begin
            // Skip the iteration; the result stage builds the fixed answer.
            zero_d  = 1'b1;
            fixed_d = 1'b1;
            state_d = StFix;
          end else begin
            zero_d  = 1'b0;
            fixed_d = 1'b0;
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        aq_d = aq_step;
        if (cnt_q == '0) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StFix: begin
        if (!fixed_q) begin
          // Non-restoring leaves A negative by one divisor when the last step overshot.
          if (aq_q[2*WIDTH]) begin
            aq_d[2*WIDTH:WIDTH] = a_fix;
          end
          fixed_d = 1'b1;
        end else begin
          if (zero_q) begin
            q_d = '1;
          end else begin
            q_d = qsign_q ? (~aq_q[WIDTH-1:0] + WIDTH'(1)) : aq_q[WIDTH-1:0];
          end
          r_d     = rsign_q ? (~r_src + WIDTH'(1)) : r_src;
          dbz_d   = zero_q;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; clear aborts any divide in flight.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      aq_q    <= '0;
      dvsr_q  <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      zero_q  <= 1'b0;
      fixed_q <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      aq_q    <= aq_d;
      dvsr_q  <= dvsr_d;
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
      zero_q  <= zero_d;
      fixed_q <= fixed_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
    end
  end

  // Status and result outputs.
  always_comb begin
    busy        = (state_q != StIdle);
    done        = (state_q == StDone);
    Q           = q_q;
    R           = r_q;
    div_by_zero = dbz_q;
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus randomized operands
// checked against 64-bit signed arithmetic.
module tb_seq_divider;

  localparam int LatNorm = 34;
  localparam int LatZero = 1;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [31:0] Dvnd, Dvsr;
  logic        busy, done, div_by_zero;
  logic [31:0] Q, R;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  seq_divider #(
    .WIDTH (32)
  ) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .Dvnd        (Dvnd),
    .Dvsr        (Dvsr),
    .busy        (busy),
    .done        (done),
    .Q           (Q),
    .R           (R),
    .div_by_zero (div_by_zero)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference: truncating signed division done in 64 bits so most-negative/-1 wraps.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic z);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
      z  = 1'b0;
    end
  endfunction

  // Issue one divide from IDLE and wait (bounded) for done. lat counts edges
  // after the accept edge; -1 means done never came.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, output int lat,
                         output logic [31:0] q, output logic [31:0] r, output logic z);
    Dvnd  = a;
    Dvsr  = b;
    start = 1'b1;
    step();
    start = 1'b0;
    Dvnd  = $urandom;
    Dvsr  = $urandom;
    lat   = -1;
    q     = '0;
    r     = '0;
    z     = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (done) begin
        lat = k;
        q   = Q;
        r   = R;
        z   = div_by_zero;
        break;
      end
      step();
    end
    step();
  endtask

  task automatic test_reset();
    clear = 1'b1;
    start = 1'b0;
    Dvnd  = '0;
    Dvsr  = '0;
    step();
    step();
    clear = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (Q !== 32'd0) begin bad++; $display("FAIL reset_Q got=%h exp=0", Q); end
    total++; if (R !== 32'd0) begin bad++; $display("FAIL reset_R got=%h exp=0", R); end
    total++;
    if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
  endtask

  task automatic test_basic();
    int lat; logic [31:0] q, r; logic z;
    run_div(32'd100, 32'd7, lat, q, r, z);
    total++; if (lat != LatNorm) begin bad++; $display("FAIL basic_lat got=%0d exp=%0d", lat, LatNorm); end
    total++; if (q !== 32'd14) begin bad++; $display("FAIL basic_Q got=%h exp=%h", q, 32'd14); end
    total++; if (r !== 32'd2) begin bad++; $display("FAIL basic_R got=%h exp=%h", r, 32'd2); end
    total++; if (z !== 1'b0) begin bad++; $display("FAIL basic_dbz got=%b exp=0", z); end
    step(); step(); step();
    total++; if (Q !== 32'd14) begin bad++; $display("FAIL basic_hold_Q got=%h exp=%h", Q, 32'd14); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_signs();
    logic [31:0] ta[6] = '{32'hFFFF_FF9C, 32'd100, 32'hFFFF_FF9C, 32'h8000_0000, 32'h8000_0000, 32'd7};
    logic [31:0] tb[6] = '{32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd1, 32'd100};
    logic [31:0] tq[6] = '{32'hFFFF_FFF2, 32'hFFFF_FFF2, 32'd14, 32'h8000_0000, 32'h8000_0000, 32'd0};
    logic [31:0] tr[6] = '{32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFE, 32'd0, 32'd0, 32'd7};
    int lat; logic [31:0] q, r; logic z;
    for (int i = 0; i < 6; i++) begin
      run_div(ta[i], tb[i], lat, q, r, z);
      total++;
      if (q !== tq[i]) begin bad++; $display("FAIL signs_Q[%0d] got=%h exp=%h", i, q, tq[i]); end
      total++;
      if (r !== tr[i]) begin bad++; $display("FAIL signs_R[%0d] got=%h exp=%h", i, r, tr[i]); end
      total++;
      if (z !== 1'b0) begin bad++; $display("FAIL signs_dbz[%0d] got=%b exp=0", i, z); end
    end
  endtask

  task automatic test_div_zero();
    int lat; logic [31:0] q, r; logic z;
    run_div(32'd5, 32'd0, lat, q, r, z);
    total++; if (lat != LatZero) begin bad++; $display("FAIL dz_lat got=%0d exp=%0d", lat, LatZero); end
    total++; if (q !== 32'hFFFF_FFFF) begin bad++; $display("FAIL dz_Q got=%h exp=ffffffff", q); end
    total++; if (r !== 32'd5) begin bad++; $display("FAIL dz_R got=%h exp=5", r); end
    total++; if (z !== 1'b1) begin bad++; $display("FAIL dz_flag got=%b exp=1", z); end
    total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dz_hold got=%b exp=1", div_by_zero); end
    run_div(32'hFFFF_FFFB, 32'd0, lat, q, r, z);
    total++; if (r !== 32'hFFFF_FFFB) begin bad++; $display("FAIL dz_neg_R got=%h exp=fffffffb", r); end
    total++; if (z !== 1'b1) begin bad++; $display("FAIL dz_neg_flag got=%b exp=1", z); end
  endtask

  task automatic test_abort();
    int lat; int pulses; logic [31:0] q, r; logic z;
    Dvnd  = 32'h0000_FF00;
    Dvsr  = 32'h10;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 9; k++) step();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy_before got=%b exp=1", busy); end
    clear = 1'b1;
    step();
    clear = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    total++; if (Q !== 32'd0) begin bad++; $display("FAIL abort_Q got=%h exp=0", Q); end
    total++; if (R !== 32'd0) begin bad++; $display("FAIL abort_R got=%h exp=0", R); end
    total++;
    if (div_by_zero !== 1'b0) begin bad++; $display("FAIL abort_dbz got=%b exp=0", div_by_zero); end
    pulses = 0;
    for (int k = 0; k < 50; k++) begin
      if (done) pulses++;
      step();
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", pulses); end
    run_div(32'h0000_FF00, 32'h10, lat, q, r, z);
    total++; if (lat != LatNorm) begin bad++; $display("FAIL abort_new_lat got=%0d exp=%0d", lat, LatNorm); end
    total++; if (q !== 32'hFF0) begin bad++; $display("FAIL abort_new_Q got=%h exp=ff0", q); end
    total++; if (r !== 32'd0) begin bad++; $display("FAIL abort_new_R got=%h exp=0", r); end
  endtask

  task automatic test_restart_ignored();
    int pulses; int first; logic [31:0] q, r;
    Dvnd  = 32'd100;
    Dvsr  = 32'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    Dvnd  = 32'd55;
    Dvsr  = 32'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    pulses = 0;
    first  = -1;
    q      = '0;
    r      = '0;
    for (int k = 5; k < 90; k++) begin
      if (done) begin
        pulses++;
        if (first < 0) begin
          first = k;
          q     = Q;
          r     = R;
        end
      end
      step();
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL restart_pulses got=%0d exp=1", pulses); end
    total++; if (first != LatNorm) begin bad++; $display("FAIL restart_lat got=%0d exp=%0d", first, LatNorm); end
    total++; if (q !== 32'd14) begin bad++; $display("FAIL restart_Q got=%h exp=e", q); end
    total++; if (r !== 32'd2) begin bad++; $display("FAIL restart_R got=%h exp=2", r); end
  endtask

  task automatic test_back_to_back();
    int lat;
    Dvnd  = 32'd1000;
    Dvsr  = 32'd10;
    start = 1'b1;
    step();
    lat = -1;
    for (int k = 0; k < 100; k++) begin
      if (done) begin lat = k; break; end
      step();
    end
    total++; if (lat != LatNorm) begin bad++; $display("FAIL b2b_lat got=%0d exp=%0d", lat, LatNorm); end
    total++; if (Q !== 32'd100) begin bad++; $display("FAIL b2b_Q got=%h exp=64", Q); end
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b exp=0", busy); end
    Dvnd = 32'd900;
    Dvsr = 32'd30;
    step();
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b exp=1", busy); end
    lat = -1;
    for (int k = 0; k < 100; k++) begin
      if (done) begin lat = k; break; end
      step();
    end
    total++; if (lat != LatNorm) begin bad++; $display("FAIL b2b_lat2 got=%0d exp=%0d", lat, LatNorm); end
    total++; if (Q !== 32'd30) begin bad++; $display("FAIL b2b_Q2 got=%h exp=1e", Q); end
    step();
  endtask

  task automatic test_random();
    int lat; int sel; logic [31:0] a, b, q, r, eq, er; logic z, ez;
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      b = 32'd0;
      else if (sel == 1) b = ($urandom_range(0, 1) == 1) ? 32'd1 : 32'hFFFF_FFFF;
      else if (sel < 5)  b = 32'($urandom_range(1, 20));
      else               b = $urandom;
      if (sel >= 2 && sel < 5 && $urandom_range(0, 1) == 1) b = -b;
      sel = $urandom_range(0, 5);
      if (sel == 0)      a = 32'h8000_0000;
      else if (sel == 1) a = 32'($urandom_range(0, 200)) - 32'd100;
      else               a = $urandom;
      ref_div(a, b, eq, er, ez);
      run_div(a, b, lat, q, r, z);
      total++;
      if (lat != (ez ? LatZero : LatNorm)) begin
        bad++;
        $display("FAIL rand_lat a=%h b=%h got=%0d exp=%0d", a, b, lat, ez ? LatZero : LatNorm);
      end
      total++;
      if (q !== eq) begin bad++; $display("FAIL rand_Q a=%h b=%h got=%h exp=%h", a, b, q, eq); end
      total++;
      if (r !== er) begin bad++; $display("FAIL rand_R a=%h b=%h got=%h exp=%h", a, b, r, er); end
      total++;
      if (z !== ez) begin bad++; $display("FAIL rand_dbz a=%h b=%h got=%b exp=%b", a, b, z, ez); end
    end
  endtask

  initial begin
    clear = 1'b0;
    start = 1'b0;
    Dvnd  = '0;
    Dvsr  = '0;
    test_reset();
    test_basic();
    test_signs();
    test_div_zero();
    test_abort();
    test_restart_ignored();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
